tiny_rv_rf_ctrl: RTL and testbench
==================================

Name: tiny_rv_rf_ctrl

Overview:
- Sequences the core's dual-read/single-write register file (32 x 32-bit, no reset, writes `write_addr1`/`write_data1` on every clock edge).
- Zeroes the array after reset, then arbitrates the single write port between two sources: ALU writeback and load-return writeback.
- Keeps a scoreboard of outstanding load destinations and drives a read-after-write hazard flag to issue.

Parameters:
- XLEN, 32: data width of the register file and writeback paths.
- INIT_ZERO, 1: 1 = run the post-reset zeroing sweep; 0 = enter RUN directly after reset.

Ports:
- i_clk  in  1  core clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous reset, active-low.
- alu_wb_valid  in  1  ALU result is available to write.
- alu_wb_addr  in  5  ALU destination register.
- alu_wb_data  in  XLEN  ALU result.
- alu_wb_ready  out  1  ALU write takes effect this cycle.
- ld_issue_valid  in  1  a load is issued; reserve its destination.
- ld_issue_addr  in  5  load destination register.
- ld_wb_valid  in  1  load data has returned (cannot be stalled).
- ld_wb_addr  in  5  returning load destination.
- ld_wb_data  in  XLEN  returning load data.
- rs1_addr  in  5  issue-stage source 1.
- rs2_addr  in  5  issue-stage source 2.
- hazard  out  1  a source register is pending, or init is in progress.
- init_busy  out  1  zeroing sweep is active.
- sb_err  out  1  sticky: load returned to a non-pending register.
- rf_write_addr  out  5  drives regfile `write_addr1`.
- rf_write_data  out  XLEN  drives regfile `write_data1`.

Behaviour:
- Clock and reset: one clock (i_clk); reset i_rst_n is asynchronous, active-low. Everything below is synchronous to i_clk.
- Reset state: FSM = INIT (or RUN if INIT_ZERO = 0); sweep counter = 0; pending[31:0] = 0; sb_err = 0.
- Output values while reset is asserted: init_busy = INIT_ZERO; hazard = INIT_ZERO; alu_wb_ready = 0; rf_write_addr = 0; rf_write_data = 0.
- Write-port outputs (rf_write_addr, rf_write_data, alu_wb_ready) are combinational from the current state and inputs. A selected write lands on the same rising edge, so write latency is 0 cycles.
- INIT state:
  - rf_write_addr = counter; rf_write_data = 0.
  - Counter increments every cycle, 0..31. After the cycle with counter = 31, go to RUN. The sweep takes exactly 32 cycles.
  - init_busy = 1, hazard = 1, alu_wb_ready = 0. ld_issue_valid and ld_wb_valid are ignored; the pending bits stay unchanged.
- RUN state, write-port priority:
  1. ld_wb_valid = 1: write ld_wb_addr / ld_wb_data; alu_wb_ready = 0.
  2. Else alu_wb_valid = 1 and pending[alu_wb_addr] = 0: write alu_wb_addr / alu_wb_data; alu_wb_ready = 1.
  3. Else alu_wb_valid = 1 and pending[alu_wb_addr] = 1: WAW stall; alu_wb_ready = 0.
  4. Idle: rf_write_addr = 0, rf_write_data = 0. This is a harmless write to x0, whose reads are masked.
- alu_wb_ready is 1 only when alu_wb_valid = 1 and the write is actually performed. The ALU holds its addr/data until it sees ready.
- A write with address 0 is always permitted and has no architectural effect. x0 is never marked pending.
- Scoreboard (RUN only), updated at the clock edge:
  - ld_issue_valid with ld_issue_addr != 0 sets pending[ld_issue_addr].
  - ld_wb_valid clears pending[ld_wb_addr].
  - Set and clear to the same address in the same cycle: the set wins, and the bit stays 1.
  - Set and clear to different addresses in the same cycle: both take effect.
- ld_wb_valid with pending[ld_wb_addr] = 0 and ld_wb_addr != 0:
  - The data is still written.
  - sb_err is set and stays 1 until reset.
- hazard = init_busy | pending[rs1_addr] | pending[rs2_addr]. It is combinational from the pending bits as they are at the start of the cycle, so a same-cycle clear is not visible until the next cycle.
- Reset asserted mid-sweep or mid-run: immediately return to reset state. Outstanding loads are forgotten. The memory side must flush its pending loads on reset as well.

Test Plan:
- Release reset with INIT_ZERO = 1, alu_wb_valid held 1 → init_busy = 1 and rf_write_addr steps 0..31 with data 0 over 32 cycles; alu_wb_ready = 0 throughout. Cycle 33: init_busy = 0, and the ALU write to x5 = 0xDEADBEEF lands with ready = 1.
- RUN: ld_issue x7; next cycle rs1 = 7 → hazard = 1. ld_wb x7 = 0x1234 → written. The cycle after: hazard = 0, pending[7] = 0.
- Same cycle: alu_wb x3 = 0xAAAA and ld_wb x7 = 0x5555 (x7 pending) → x7 written, alu_wb_ready = 0. Next cycle x3 = 0xAAAA written, ready = 1.
- ALU write to x9 while pending[9] = 1 → ready stays 0 until the cycle after ld_wb x9; then x9 is taken from the ALU, so the ALU value is the final one.
- Same cycle: ld_issue x4 and ld_wb x4 (x4 pending) → pending[4] remains 1 and hazard remains 1 for rs2 = 4. Separately, ld_issue to x0 → pending stays 0.
- ld_wb x12 while not pending → sb_err = 1 and stays 1. Assert i_rst_n = 0 mid-sweep at counter = 10 → outputs return to reset values immediately and the sweep restarts from 0 after release.

Source files
------------

// File: rtl/tiny_rv_rf_ctrl.sv
// -----------------------------------------------------------------------------
// tiny_rv_rf_ctrl
//
// Write-port sequencer and load scoreboard for the core's 32 x XLEN register
// file. The register file itself has no reset and writes write_addr1 /
// write_data1 on every rising edge, so this block always presents a write.
// When there is no useful work, that write goes to x0, whose reads are masked.
//
//   1. After reset, optionally sweeps x0..x31 with zeros (INIT state, 32 cycles).
//   2. In RUN, arbitrates the single write port. Returning loads have priority
//      because they cannot be stalled. ALU writebacks come next, unless their
//      destination still has a load outstanding (WAW).
//   3. Tracks outstanding load destinations and raises a read-after-write
//      hazard flag for the issue stage.
//
// Parameters
//   XLEN       data width of the register file and writeback paths
//   INIT_ZERO  1: run the zeroing sweep after reset; 0: go straight to RUN
//
// Ports
//   i_clk, i_rst_n            clock; asynchronous active-low reset
//   alu_wb_valid/addr/data    ALU writeback request (held until ready)
//   alu_wb_ready              the ALU write is performed this cycle
//   ld_issue_valid/addr       load issued; reserve its destination
//   ld_wb_valid/addr/data     load data returned (never stalled)
//   rs1_addr, rs2_addr        issue-stage source registers
//   hazard                    a source is pending, or init is in progress
//   init_busy                 zeroing sweep active
//   sb_err                    sticky: a load returned to a non-pending register
//   rf_write_addr/data        drive the register file's write_addr1/write_data1
// -----------------------------------------------------------------------------
module tiny_rv_rf_ctrl #(
  parameter int XLEN      = 32,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,

  input  logic            alu_wb_valid,
  input  logic [4:0]      alu_wb_addr,
  input  logic [XLEN-1:0] alu_wb_data,
  output logic            alu_wb_ready,

  input  logic            ld_issue_valid,
  input  logic [4:0]      ld_issue_addr,

  input  logic            ld_wb_valid,
  input  logic [4:0]      ld_wb_addr,
  input  logic [XLEN-1:0] ld_wb_data,

  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            hazard,
  output logic            init_busy,
  output logic            sb_err,

  output logic [4:0]      rf_write_addr,
  output logic [XLEN-1:0] rf_write_data
);

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [0:0] ST_RESET = INIT_ZERO ? ST_INIT : ST_RUN;

  localparam logic [4:0] CNT_LAST = 5'd31;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0] state_q,   state_d;
  logic [4:0] cnt_q,     cnt_d;
  logic [31:0] pending_q, pending_d;
  logic       sb_err_q,  sb_err_d;

  logic in_init;
  logic in_run;

  assign in_init = (state_q == ST_INIT);
  // i_rst_n is included so that the write port stays idle while reset is
  // asserted, even when INIT_ZERO = 0 puts the reset state in RUN.
  assign in_run  = (state_q == ST_RUN) && i_rst_n;

  // ---------------------------------------------------------------------------
  // Next-state logic: sweep counter, FSM, scoreboard, sticky error
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    sb_err_d  = sb_err_q;

    case (state_q)
      ST_INIT: begin
        // Load traffic is ignored during the sweep, so the pending bits
        // keep their current value.
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (ld_wb_valid) begin
          // A load returning to a register that is not pending means the
          // memory side and this scoreboard disagree. The data is still
          // written; the error is only flagged.
          if ((ld_wb_addr != 5'd0) && !pending_q[ld_wb_addr]) begin
            sb_err_d = 1'b1;
          end
          pending_d[ld_wb_addr] = 1'b0;
        end
        // The set is applied after the clear. A new load to a register whose
        // previous load returns in the same cycle therefore stays pending.
        if (ld_issue_valid && (ld_issue_addr != 5'd0)) begin
          pending_d[ld_issue_addr] = 1'b1;
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase

    // x0 is never reserved.
    pending_d[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // the values from before the edge, whatever the statement order.
  // NOTE: the register array downstream is deliberately not reset (the sweep
  // clears it). The pending bits are reset, so loads in flight at reset are
  // forgotten.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_RESET;
      cnt_q     <= 5'd0;
      pending_q <= 32'd0;
      sb_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-port arbitration (combinational; the write lands on this edge)
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_write_addr = 5'd0;
    rf_write_data = '0;
    alu_wb_ready  = 1'b0;

    if (in_init) begin
      rf_write_addr = cnt_q;
      rf_write_data = '0;
    end else if (in_run) begin
      if (ld_wb_valid) begin
        rf_write_addr = ld_wb_addr;
        rf_write_data = ld_wb_data;
      end else if (alu_wb_valid && !pending_q[alu_wb_addr]) begin
        rf_write_addr = alu_wb_addr;
        rf_write_data = alu_wb_data;
        alu_wb_ready  = 1'b1;
      end
      // Otherwise the port is idle, or the ALU is stalled by WAW on a pending
      // destination. Both cases fall back to the harmless write of zero to x0.
    end
  end

  // ---------------------------------------------------------------------------
  // Issue-side status
  // ---------------------------------------------------------------------------
  // The hazard flag uses the pending bits as they were at the start of the
  // cycle. A load returning this cycle clears the hazard one cycle later.
  assign init_busy = in_init;
  assign hazard    = in_init | pending_q[rs1_addr] | pending_q[rs2_addr];
  assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_tiny_rv_rf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tiny_rv_rf_ctrl
//
// Bench for tiny_rv_rf_ctrl (XLEN = 32, INIT_ZERO = 1). The clock has a 10 ns
// period. Inputs change 1 ns after each rising edge. Outputs are sampled on the
// falling edge.
//
// A bench-side copy of the register file captures every write that the DUT
// presents, so the final architectural contents can be checked as well as the
// cycle-by-cycle port values.
// -----------------------------------------------------------------------------
module tb_tiny_rv_rf_ctrl;

  localparam int XLEN = 32;

  logic            i_clk;
  logic            i_rst_n;
  logic            alu_wb_valid;
  logic [4:0]      alu_wb_addr;
  logic [XLEN-1:0] alu_wb_data;
  logic            alu_wb_ready;
  logic            ld_issue_valid;
  logic [4:0]      ld_issue_addr;
  logic            ld_wb_valid;
  logic [4:0]      ld_wb_addr;
  logic [XLEN-1:0] ld_wb_data;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            hazard;
  logic            init_busy;
  logic            sb_err;
  logic [4:0]      rf_write_addr;
  logic [XLEN-1:0] rf_write_data;

  tiny_rv_rf_ctrl #(.XLEN(XLEN), .INIT_ZERO(1'b1)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .alu_wb_valid   (alu_wb_valid),
    .alu_wb_addr    (alu_wb_addr),
    .alu_wb_data    (alu_wb_data),
    .alu_wb_ready   (alu_wb_ready),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_addr  (ld_issue_addr),
    .ld_wb_valid    (ld_wb_valid),
    .ld_wb_addr     (ld_wb_addr),
    .ld_wb_data     (ld_wb_data),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .hazard         (hazard),
    .init_busy      (init_busy),
    .sb_err         (sb_err),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Bench copy of the register file: it writes on every edge, as the real one does.
  logic [XLEN-1:0] rf_model [32];
  always @(posedge i_clk) begin
    if (i_rst_n) rf_model[rf_write_addr] <= rf_write_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus plus the outputs expected in that same cycle.
  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_a;
    logic [31:0] alu_d;
    logic        li_v;
    logic [4:0]  li_a;
    logic        lw_v;
    logic [4:0]  lw_a;
    logic [31:0] lw_d;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_rdy;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_hz;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(
    input logic alu_v, input logic [4:0] alu_a, input logic [31:0] alu_d,
    input logic li_v,  input logic [4:0] li_a,
    input logic lw_v,  input logic [4:0] lw_a,  input logic [31:0] lw_d,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic e_rdy, input logic [4:0] e_addr, input logic [31:0] e_data,
    input logic e_hz,  input logic e_err);
    vec_t v;
    v.alu_v = alu_v; v.alu_a = alu_a; v.alu_d = alu_d;
    v.li_v  = li_v;  v.li_a  = li_a;
    v.lw_v  = lw_v;  v.lw_a  = lw_a;  v.lw_d  = lw_d;
    v.rs1   = rs1;   v.rs2   = rs2;
    v.e_rdy = e_rdy; v.e_addr = e_addr; v.e_data = e_data;
    v.e_hz  = e_hz;  v.e_err  = e_err;
    return v;
  endfunction

  vec_t exp_q [$];

  task automatic drive(input vec_t v);
    alu_wb_valid   = v.alu_v;
    alu_wb_addr    = v.alu_a;
    alu_wb_data    = v.alu_d;
    ld_issue_valid = v.li_v;
    ld_issue_addr  = v.li_a;
    ld_wb_valid    = v.lw_v;
    ld_wb_addr     = v.lw_a;
    ld_wb_data     = v.lw_d;
    rs1_addr       = v.rs1;
    rs2_addr       = v.rs2;
  endtask

  task automatic idle();
    drive(mk(0,0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0,0));
  endtask

  // Checks the sweep cycle by cycle. The caller has just released reset,
  // 1 ns after a rising edge.
  task automatic check_sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge i_clk);
      check($sformatf("%s_busy%0d", tag, i), {31'd0, init_busy}, 32'd1);
      check($sformatf("%s_addr%0d", tag, i), {27'd0, rf_write_addr}, i);
      check($sformatf("%s_data%0d", tag, i), rf_write_data, 32'd0);
      check($sformatf("%s_rdy%0d",  tag, i), {31'd0, alu_wb_ready}, 32'd0);
      check($sformatf("%s_hz%0d",   tag, i), {31'd0, hazard}, 32'd1);
      @(posedge i_clk); #1;
    end
  endtask

  vec_t tbl [28];

  initial begin
    vec_t e;

    tbl[0]  = mk(0,0,0,        0,0,  0,0,0,         0,0,   0,0,0,         0,0);
    tbl[1]  = mk(0,0,0,        1,7,  0,0,0,         0,0,   0,0,0,         0,0); // issue load x7
    tbl[2]  = mk(0,0,0,        0,0,  0,0,0,         7,0,   0,0,0,         1,0); // rs1=7 hazard
    tbl[3]  = mk(0,0,0,        0,0,  1,7,32'h1234,  7,0,   0,7,32'h1234,  1,0); // return x7; hazard still visible
    tbl[4]  = mk(0,0,0,        0,0,  0,0,0,         7,0,   0,0,0,         0,0); // cleared
    tbl[5]  = mk(0,0,0,        1,7,  0,0,0,         0,0,   0,0,0,         0,0);
    tbl[6]  = mk(1,3,32'hAAAA, 0,0,  1,7,32'h5555,  0,0,   0,7,32'h5555,  0,0); // load beats ALU
    tbl[7]  = mk(1,3,32'hAAAA, 0,0,  0,0,0,         0,0,   1,3,32'hAAAA,  0,0); // ALU retried
    tbl[8]  = mk(0,0,0,        1,9,  0,0,0,         0,0,   0,0,0,         0,0);
    tbl[9]  = mk(1,9,32'h9999, 0,0,  0,0,0,         9,0,   0,0,0,         1,0); // WAW stall
    tbl[10] = mk(1,9,32'h9999, 0,0,  1,9,32'h0BAD,  9,0,   0,9,32'h0BAD,  1,0);
    tbl[11] = mk(1,9,32'h9999, 0,0,  0,0,0,         9,0,   1,9,32'h9999,  0,0); // ALU value is final
    tbl[12] = mk(0,0,0,        1,4,  0,0,0,         0,0,   0,0,0,         0,0);
    tbl[13] = mk(0,0,0,        1,4,  1,4,32'h44,    0,4,   0,4,32'h44,    1,0); // set wins over clear
    tbl[14] = mk(0,0,0,        0,0,  0,0,0,         0,4,   0,0,0,         1,0);
    tbl[15] = mk(0,0,0,        0,0,  1,4,32'h45,    0,4,   0,4,32'h45,    1,0);
    tbl[16] = mk(0,0,0,        0,0,  0,0,0,         0,4,   0,0,0,         0,0);
    tbl[17] = mk(0,0,0,        1,0,  0,0,0,         0,0,   0,0,0,         0,0); // issue to x0
    tbl[18] = mk(0,0,0,        0,0,  0,0,0,         0,0,   0,0,0,         0,0); // x0 not pending
    tbl[19] = mk(0,0,0,        1,11, 0,0,0,         0,0,   0,0,0,         0,0);
    tbl[20] = mk(0,0,0,        1,10, 1,11,32'h11,   10,11, 0,11,32'h11,   1,0); // set/clear, different regs
    tbl[21] = mk(0,0,0,        0,0,  0,0,0,         10,11, 0,0,0,         1,0);
    tbl[22] = mk(0,0,0,        0,0,  0,0,0,         11,0,  0,0,0,         0,0);
    tbl[23] = mk(0,0,0,        0,0,  1,10,32'h10,   0,0,   0,10,32'h10,   0,0);
    tbl[24] = mk(0,0,0,        0,0,  1,12,32'hC,    0,0,   0,12,32'hC,    0,0); // unexpected return
    tbl[25] = mk(0,0,0,        0,0,  0,0,0,         0,0,   0,0,0,         0,1); // sticky error
    tbl[26] = mk(1,0,32'h77,   0,0,  0,0,0,         0,0,   1,0,32'h77,    0,1); // ALU to x0 permitted
    tbl[27] = mk(0,0,0,        1,6,  0,0,0,         0,0,   0,0,0,         0,1); // left pending across reset

    // Reset is asserted with the ALU already requesting x5.
    i_rst_n = 1'b0;
    idle();
    alu_wb_valid = 1'b1;
    alu_wb_addr  = 5'd5;
    alu_wb_data  = 32'hDEADBEEF;
    #2;
    check("rst_busy", {31'd0, init_busy},    32'd1);
    check("rst_hz",   {31'd0, hazard},       32'd1);
    check("rst_rdy",  {31'd0, alu_wb_ready}, 32'd0);
    check("rst_addr", {27'd0, rf_write_addr}, 32'd0);
    check("rst_data", rf_write_data,          32'd0);
    check("rst_err",  {31'd0, sb_err},        32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    check_sweep("init");

    // First RUN cycle: the held ALU write lands.
    @(negedge i_clk);
    check("run0_busy", {31'd0, init_busy},     32'd0);
    check("run0_rdy",  {31'd0, alu_wb_ready},  32'd1);
    check("run0_addr", {27'd0, rf_write_addr}, 32'd5);
    check("run0_data", rf_write_data,          32'hDEADBEEF);
    check("run0_hz",   {31'd0, hazard},        32'd0);
    @(posedge i_clk); #1;

    for (int i = 0; i < 28; i++) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(negedge i_clk);
      e = exp_q.pop_front();
      check($sformatf("v%0d_rdy",  i), {31'd0, alu_wb_ready},  {31'd0, e.e_rdy});
      check($sformatf("v%0d_addr", i), {27'd0, rf_write_addr}, {27'd0, e.e_addr});
      check($sformatf("v%0d_data", i), rf_write_data,          e.e_data);
      check($sformatf("v%0d_hz",   i), {31'd0, hazard},        {31'd0, e.e_hz});
      check($sformatf("v%0d_err",  i), {31'd0, sb_err},        {31'd0, e.e_err});
      @(posedge i_clk); #1;
    end
    idle();

    // Architectural contents seen by the bench copy of the register file.
    @(negedge i_clk);
    check("rf_x5",  rf_model[5],  32'hDEADBEEF);
    check("rf_x3",  rf_model[3],  32'hAAAA);
    check("rf_x7",  rf_model[7],  32'h5555);
    check("rf_x9",  rf_model[9],  32'h9999);
    check("rf_x4",  rf_model[4],  32'h45);
    check("rf_x11", rf_model[11], 32'h11);
    check("rf_x10", rf_model[10], 32'h10);
    check("rf_x12", rf_model[12], 32'hC);
    check("rf_x20", rf_model[20], 32'd0);
    check("rf_x31", rf_model[31], 32'd0);
    check("pend6",  {31'd0, hazard}, 32'd0);
    @(posedge i_clk); #1;

    // Reset: restart the sweep, then abort it at counter 10.
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge i_clk);
      check($sformatf("pre_addr%0d", i), {27'd0, rf_write_addr}, i);
      if (i < 10) begin
        @(posedge i_clk); #1;
      end
    end
    i_rst_n = 1'b0;
    #1;
    check("mid_addr", {27'd0, rf_write_addr}, 32'd0);
    check("mid_busy", {31'd0, init_busy},     32'd1);
    check("mid_hz",   {31'd0, hazard},        32'd1);
    check("mid_err",  {31'd0, sb_err},        32'd0);
    check("mid_rdy",  {31'd0, alu_wb_ready},  32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    check_sweep("re");

    // After the sweep: no stale pending bits (x6 was reserved before reset),
    // and the sticky error has been cleared.
    rs1_addr = 5'd6;
    rs2_addr = 5'd4;
    @(negedge i_clk);
    check("post_busy", {31'd0, init_busy}, 32'd0);
    check("post_hz",   {31'd0, hazard},    32'd0);
    check("post_err",  {31'd0, sb_err},    32'd0);
    @(posedge i_clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
